// File: rtl/div_pkg.sv
// Shared types and constants for the integer divide controller.
// Operand extension helpers live here so issue-side logic can reuse them.
package div_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_EXT_W = 33;
  localparam logic [DIV_W-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    DRAIN,
    DONE
  } div_state_e;

  function automatic logic is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

  // Signed ops sign-extend, unsigned ops zero-extend, so one signed divider serves both.
  function automatic logic [DIV_EXT_W-1:0] ext_op(input div_op_e op, input logic [DIV_W-1:0] v);
    return {((op == DIV) || (op == REM)) & v[DIV_W-1], v};
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Issue-side request and writeback-side response channels of the divide controller.
// master = issue/writeback side, slave = controller.
interface div_ctrl_if import div_pkg::*; #(parameter int unsigned TAG_W = 5);

  logic             req_valid;
  logic             req_ready;
  div_op_e          req_op;
  logic [DIV_W-1:0] req_a;
  logic [DIV_W-1:0] req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [DIV_W-1:0] resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );

endinterface

// File: rtl/div_ctrl_div.sv
// 33-bit signed sequential divider with registered inputs.
// complete rises NUM_CYC-1 edges after the start edge and holds until the next start.
module DW_div_seq_inst_signed import div_pkg::*; #(
  parameter int unsigned NUM_CYC = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        hold_i,
  input  logic                        start_i,
  input  logic signed [DIV_EXT_W-1:0] a_i,
  input  logic signed [DIV_EXT_W-1:0] b_i,
  output logic                        complete_o,
  output logic signed [DIV_EXT_W-1:0] quotient_o,
  output logic signed [DIV_EXT_W-1:0] remainder_o
);

  localparam int unsigned CW = $clog2(NUM_CYC);

  logic signed [DIV_EXT_W-1:0] a_q, b_q, quot_q, rem_q;
  logic [CW-1:0]               cnt_q;
  logic                        run_q, done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      cnt_q  <= CW'(1);
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q && !hold_i) begin
      if (cnt_q == CW'(NUM_CYC - 1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
        if (b_q == '0) begin
          quot_q <= '1;
          rem_q  <= a_q;
        end else begin
          quot_q <= a_q / b_q;
          rem_q  <= a_q % b_q;
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign complete_o  = done_q;
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU/REM/REMU sequencer: extends operands, runs the sequential divider,
// resolves divide-by-zero without it, and holds the result until writeback takes it.
module div_ctrl import div_pkg::*; #(
  parameter int unsigned NUM_CYC = 9,
  parameter int unsigned TAG_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  output logic       busy,
  div_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(NUM_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CYC - 1);

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  div_op_e              op_q, op_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [DIV_EXT_W-1:0] a_q, a_d, b_q, b_d;
  logic [DIV_W-1:0]     data_q, data_d;

  logic                 div_start, div_complete, div_rst_n, accept;
  logic [DIV_EXT_W-1:0] div_quot, div_rem;
  logic                 div_unused;

  assign div_rst_n  = ~rst;
  assign div_unused = div_quot[DIV_EXT_W-1] ^ div_rem[DIV_EXT_W-1];

  DW_div_seq_inst_signed #(.NUM_CYC(NUM_CYC)) u_div (
    .clk        (clk),
    .rst_n      (div_rst_n),
    .hold_i     (1'b0),
    .start_i    (div_start),
    .a_i        (a_q),
    .b_i        (b_q),
    .complete_o (div_complete),
    .quotient_o (div_quot),
    .remainder_o(div_rem)
  );

  assign bus.req_ready  = (state_q == IDLE) && !flush;
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_data  = data_q;
  assign bus.resp_tag   = tag_q;
  assign busy           = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= DIV;
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = bus.req_op;
          tag_d = bus.req_tag;
          a_d   = ext_op(bus.req_op, bus.req_a);
          b_d   = ext_op(bus.req_op, bus.req_b);
          if (bus.req_b == '0) begin
            data_d  = is_rem(bus.req_op) ? bus.req_a : DIV0_QUOT;
            state_d = DONE;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        div_start = 1'b1;
        cnt_d     = '0;
        state_d   = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        // A flush on the final count finds the divider already finished: nothing to drain.
        if (cnt_q == LAST) begin
          if (!flush) begin
            data_d = is_rem(op_q) ? div_rem[DIV_W-1:0] : div_quot[DIV_W-1:0];
          end
          state_d = flush ? IDLE : DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = flush ? DRAIN : WAIT;
        end
      end
      DRAIN: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (flush || bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  div_done_chk: assert property (@(posedge clk) disable iff (rst)
    (state_q == WAIT && cnt_q == LAST) |-> div_complete);

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: expected results queued at issue, compared at writeback.
module tb_div_ctrl;
  import div_pkg::*;

  localparam int unsigned NUM_CYC = 9;
  localparam int unsigned TAG_W   = 5;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk, rst, flush, busy;
  int   tests_run, tests_failed, start_cnt, resp_hs;
  exp_t sb[$];

  div_ctrl_if #(.TAG_W(TAG_W)) bus ();

  div_ctrl #(.NUM_CYC(NUM_CYC), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .busy (busy),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dut.div_start) start_cnt++;
    if (!rst && bus.resp_valid && bus.resp_ready && !flush) begin
      resp_hs++;
      if (sb.size() == 0) begin
        chk("sb_unexpected_resp", 64'(bus.resp_data), 64'hdead);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", 64'(bus.resp_data), 64'(e.data));
        chk("sb_tag", 64'(bus.resp_tag), 64'(e.tag));
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accept edge.
  task automatic drive_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag);
    int n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("accept_timeout", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Latency in the edge-sampled sense: 1 means the first edge after accept sees resp_valid.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.resp_valid) chk("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue_chk(input string name, input div_op_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag,
                           input logic [31:0] exp, input int exp_lat);
    int lat;
    sb.push_back('{data: exp, tag: tag});
    drive_op(op, a, b, tag);
    wait_resp(lat);
    chk(name, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    int lat, edges, s0, h0;
    tests_run = 0; tests_failed = 0; start_cnt = 0; resp_hs = 0;
    rst = 1'b1; flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = DIV; bus.req_a = '0; bus.req_b = '0;
    bus.req_tag = '0; bus.resp_ready = 1'b1;
    #2;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
    chk("rst_resp_tag", 64'(bus.resp_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    issue_chk("lat_div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, NUM_CYC + 2);
    issue_chk("lat_rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, NUM_CYC + 2);
    issue_chk("lat_divu", DIVU, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'h7FFF_FFFF, NUM_CYC + 2);
    issue_chk("lat_remu", REMU, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'h0000_0001, NUM_CYC + 2);

    s0 = start_cnt;
    issue_chk("lat_div_by0", DIV, 32'd5, 32'd0, 5'd5, 32'hFFFF_FFFF, 1);
    issue_chk("lat_remu_by0", REMU, 32'd5, 32'd0, 5'd6, 32'd5, 1);
    @(posedge clk);
    #1;
    chk("by0_no_start", 64'(start_cnt - s0), 64'd0);

    issue_chk("lat_div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, NUM_CYC + 2);
    issue_chk("lat_rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, NUM_CYC + 2);

    // Flush while idle blocks a simultaneous request.
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1; bus.req_op = DIV; bus.req_a = 32'd9; bus.req_b = 32'd3;
    flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", 64'(busy), 64'd0);

    // Flush three cycles after accept: drained, no response.
    h0 = resp_hs;
    drive_op(DIV, 32'd77, 32'd5, 5'd20);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    edges = 4;
    chk("drain_ready_lo", 64'(bus.req_ready), 64'd0);
    chk("drain_busy", 64'(busy), 64'd1);
    while (!bus.req_ready && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("drain_len", 64'(edges), 64'(NUM_CYC + 1));
    chk("flush_no_resp", 64'(resp_hs - h0), 64'd0);
    issue_chk("lat_after_flush", DIVU, 32'd10, 32'd3, 5'd9, 32'd3, NUM_CYC + 2);

    // Flush in DONE wins over resp_ready.
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    drive_op(DIVU, 32'd20, 32'd4, 5'd11);
    wait_resp(lat);
    chk("lat_done_flush", 64'(lat), 64'(NUM_CYC + 2));
    flush = 1'b1; bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("done_flush_valid", 64'(bus.resp_valid), 64'd0);
    chk("done_flush_busy", 64'(busy), 64'd0);

    // Writeback stall: payload held.
    bus.resp_ready = 1'b0;
    sb.push_back('{data: 32'd14, tag: 5'd12});
    drive_op(DIV, 32'd100, 32'd7, 5'd12);
    wait_resp(lat);
    chk("lat_stall", 64'(lat), 64'(NUM_CYC + 2));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 64'(bus.resp_valid), 64'd1);
      chk("stall_data", 64'(bus.resp_data), 64'd14);
      chk("stall_tag", 64'(bus.resp_tag), 64'd12);
      chk("stall_busy", 64'(busy), 64'd1);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release", 64'(bus.resp_valid), 64'd0);

    // Asynchronous reset in the middle of WAIT.
    drive_op(DIV, 32'd50, 32'd3, 5'd13);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("midrst_resp_data", 64'(bus.resp_data), 64'd0);
    chk("midrst_resp_tag", 64'(bus.resp_tag), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue_chk("lat_post_rst", DIV, 32'd100, 32'hFFFF_FFF9, 5'd14, 32'hFFFF_FFF2, NUM_CYC + 2);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
